// File: rtl/data_sram_arb.sv
// data_sram_arb: two-requester arbiter for the data SRAM port, routing 1-cycle responses to the issuing requester with aux starvation relief.
module data_sram_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_wr,
  input  logic [3:0]  aux_wstrb,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_addr_ok,
  output logic        aux_data_ok,
  output logic [31:0] aux_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);
  logic             rsp_valid, rsp_owner, rsp_wr;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved, gnt_aux, gnt_cpu, busy, win_wr;
  always_comb begin
    starved         = starve_cnt == CNT_W'(STARVE_LIMIT);
    gnt_aux         = resetn & aux_req & (~cpu_req | starved);
    gnt_cpu         = resetn & cpu_req & ~gnt_aux;
    busy            = gnt_aux | gnt_cpu;
    win_wr          = gnt_aux ? aux_wr : cpu_wr;
    cpu_addr_ok     = gnt_cpu;
    aux_addr_ok     = gnt_aux;
    data_sram_en    = busy;
    data_sram_wen   = (busy & win_wr) ? (gnt_aux ? aux_wstrb : cpu_wstrb) : 4'h0;
    data_sram_addr  = gnt_aux ? aux_addr : gnt_cpu ? cpu_addr : 32'h0;
    data_sram_wdata = gnt_aux ? aux_wdata : gnt_cpu ? cpu_wdata : 32'h0;
    cpu_data_ok     = rsp_valid & ~rsp_owner;
    aux_data_ok     = rsp_valid & rsp_owner;
    cpu_rdata       = (cpu_data_ok & ~rsp_wr) ? data_sram_rdata : 32'h0;
    aux_rdata       = (aux_data_ok & ~rsp_wr) ? data_sram_rdata : 32'h0;
  end
  // rsp_wr suppresses SRAM read data on write responses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid  <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_wr     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rsp_valid  <= busy;
      rsp_owner  <= gnt_aux;
      rsp_wr     <= busy & win_wr;
      starve_cnt <= (aux_req & ~gnt_aux) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
    end
  end
endmodule

// File: tb/tb_data_sram_arb.sv
// tb_data_sram_arb: directed-step bench for data_sram_arb with immediate assertions.
module tb_data_sram_arb;
  logic        clk = 0, resetn = 0;
  logic        cpu_req = 0, cpu_wr = 0, aux_req = 0, aux_wr = 0;
  logic [3:0]  cpu_wstrb = 0, aux_wstrb = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, aux_addr = 0, aux_wdata = 0, data_sram_rdata = 0;
  logic        cpu_addr_ok, cpu_data_ok, aux_addr_ok, aux_data_ok, data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] cpu_rdata, aux_rdata, data_sram_addr, data_sram_wdata;
  int          total = 0, passed = 0;
  logic        pv = 0, pa = 0, pw = 0;

  data_sram_arb #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_wr(aux_wr), .aux_wstrb(aux_wstrb), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_addr_ok(aux_addr_ok), .aux_data_ok(aux_data_ok), .aux_rdata(aux_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: inputs already driven after a falling edge; g = expected grant (0 none, 1 cpu, 2 aux)
  task automatic cyc(input int g, input logic [31:0] rd);
    logic [3:0]  ew;
    logic [31:0] ea, ed;
    data_sram_rdata = rd;
    #1;
    chk("cpu_data_ok", cpu_data_ok, pv && !pa);
    chk("aux_data_ok", aux_data_ok, pv && pa);
    chk("cpu_rdata", cpu_rdata, (pv && !pa && !pw) ? rd : 32'h0);
    chk("aux_rdata", aux_rdata, (pv && pa && !pw) ? rd : 32'h0);
    chk("cpu_addr_ok", cpu_addr_ok, g == 1);
    chk("aux_addr_ok", aux_addr_ok, g == 2);
    chk("sram_en", data_sram_en, g != 0);
    ea = g == 1 ? cpu_addr : g == 2 ? aux_addr : 32'h0;
    ed = g == 1 ? cpu_wdata : g == 2 ? aux_wdata : 32'h0;
    ew = g == 1 ? (cpu_wr ? cpu_wstrb : 4'h0) : g == 2 ? (aux_wr ? aux_wstrb : 4'h0) : 4'h0;
    chk("sram_addr", data_sram_addr, ea);
    chk("sram_wdata", data_sram_wdata, ed);
    chk("sram_wen", {28'h0, data_sram_wen}, {28'h0, ew});
    pv = g != 0;
    pa = g == 2;
    pw = g == 1 ? cpu_wr : aux_wr;
    @(negedge clk);
  endtask

  initial begin
    cpu_req = 1; cpu_addr = 32'h55; aux_req = 1; aux_addr = 32'h66;
    #1;
    chk("rst cpu_addr_ok", cpu_addr_ok, 0);
    chk("rst aux_addr_ok", aux_addr_ok, 0);
    chk("rst sram_en", data_sram_en, 0);
    chk("rst sram_addr", data_sram_addr, 0);
    chk("rst cpu_data_ok", cpu_data_ok, 0);
    @(negedge clk);
    resetn = 1; aux_req = 0; cpu_req = 1; cpu_wr = 0; cpu_wstrb = 4'hf; cpu_addr = 32'h100;
    cyc(1, 32'h0);
    cpu_req = 0; aux_req = 1; aux_wr = 1; aux_wstrb = 4'b0011; aux_addr = 32'h20; aux_wdata = 32'h1234;
    cyc(2, 32'hDEADBEEF);
    aux_req = 0; aux_wr = 0;
    cyc(0, 32'hFFFFFFFF);
    // continuous contention: cpu x4 then aux, repeating
    cpu_req = 1; aux_req = 1; cpu_wr = 0; aux_wr = 0;
    for (int i = 0; i < 12; i++) begin
      cpu_addr = 32'h1000 + i; aux_addr = 32'h2000 + i;
      cyc((i % 5 == 4) ? 2 : 1, 32'hA0000000 + i);
    end
    cpu_req = 0; aux_req = 0;
    cyc(0, 32'hBEEF0001);
    // back-to-back mixed ownership
    cpu_req = 1; cpu_addr = 32'hA00;
    cyc(1, 32'h0);
    cpu_req = 0; aux_req = 1; aux_addr = 32'hB00;
    cyc(2, 32'h11111111);
    aux_req = 0; cpu_req = 1; cpu_addr = 32'hC00;
    cyc(1, 32'h22222222);
    cpu_req = 0;
    cyc(0, 32'h33333333);
    // build starvation, then reset while a cpu response is pending
    cpu_req = 1; aux_req = 1;
    cyc(1, 32'h0);
    cyc(1, 32'h0);
    data_sram_rdata = 32'h77777777;
    #1;
    chk("pre-rst cpu_addr_ok", cpu_addr_ok, 1);
    #2 resetn = 0;
    #1;
    chk("async cpu_addr_ok", cpu_addr_ok, 0);
    chk("async sram_en", data_sram_en, 0);
    chk("async sram_addr", data_sram_addr, 0);
    chk("async cpu_data_ok", cpu_data_ok, 0);
    chk("async cpu_rdata", cpu_rdata, 0);
    pv = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 5; i++) cyc((i == 4) ? 2 : 1, 32'hC0DE0000 + i);
    cpu_req = 0; aux_req = 0;
    for (int i = 0; i < 10; i++) cyc(0, 32'h99990000 + i);
    // cpu streams with aux idle, then contention must start fresh
    cpu_req = 1;
    for (int i = 0; i < 6; i++) cyc(1, 32'h0);
    aux_req = 1;
    for (int i = 0; i < 5; i++) cyc((i == 4) ? 2 : 1, 32'h5A5A0000 + i);
    cpu_req = 0; aux_req = 0;
    cyc(0, 32'h12345678);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
